i2c_lcd_target: RTL and testbench
=================================

// Module: i2c_lcd_target
// PURPOSE
//  I2C target (responder) emulating the PCF8574 backpack at the far end of the LCD I2C write path.
//  Decodes START/STOP/address/data on scl/sda, ACKs its address, holds the 8-bit expander port.
//  Reassembles HD44780 4-bit transfers (E falling edges) into command/data bytes for on-chip checking/display mirroring.
// PARAMETERS
//  I2C_ADDR   7'h27   7-bit target address matched against the first byte after START
//  PORT_RST   8'h00   port_out value after reset
// PORTS
//  clk        in   1  system clock, >= 8x SCL rate; all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  scl_in     in   1  raw SCL level from the pad (asynchronous)
//  sda_in     in   1  raw SDA level from the pad (asynchronous)
//  sda_oe     out  1  1 = pull SDA low (open drain); 0 = release
//  nib_clr    in   1  1-cycle pulse: force nibble phase to HIGH (resync)
//  port_out   out  8  expander pins P7..P0 (P7..P4=D7..D4, P3=BL, P2=E, P1=RW, P0=RS)
//  port_wr    out  1  1-cycle pulse, port_out updated this cycle
//  lcd_valid  out  1  1-cycle pulse, lcd_byte/lcd_rs valid
//  lcd_byte   out  8  reassembled {high nibble, low nibble}
//  lcd_rs     out  1  RS latched with the low nibble (0 = command, 1 = data)
//  busy       out  1  1 between START and STOP (any address)
// BEHAVIOUR
//  Reset: sda_oe=0, port_out=PORT_RST, port_wr=0, lcd_valid=0, lcd_byte=0, lcd_rs=0, busy=0, FSM=IDLE, phase=HIGH.
//  Input: scl_in/sda_in through 2-FF synchronisers; edges from synced value vs 1-cycle delayed copy (3-cycle latency).
//  START: SDA fall while SCL high; STOP: SDA rise while SCL high. Both take priority over bit sampling.
//  Bits sampled on SCL rise, MSB first; sda_oe only changes on SCL fall (never while SCL high).
//  FSM: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//   IDLE -START-> ADDR (busy=1). ADDR: 8 bits; at 8th-bit SCL fall: match & R/W=0 -> ADDR_ACK (sda_oe=1);
//   match & R/W=1 -> see CONFIGURATION; mismatch -> IGNORE (sda_oe=0).
//   ADDR_ACK/WR_ACK: hold sda_oe=1 until next SCL fall, then release -> WR_DATA.
//   WR_DATA: 8 bits; at 8th-bit SCL fall: port_out<=byte, port_wr=1 for that cycle, sda_oe=1 -> WR_ACK.
//   IGNORE: sda_oe=0, no port updates, wait for START/STOP.
//   Any state: STOP -> IDLE, sda_oe=0, busy=0 same cycle; START (repeated) -> ADDR, sda_oe=0, bit counter=0.
//   START/STOP mid-byte: partial byte discarded, port_out unchanged.
//  Nibble decode on each port_wr: if old P2=1, new P2=0 and old P1=0 (write strobe):
//   phase HIGH: hi<=old[7:4], phase<=LOW. phase LOW: lcd_byte<={hi,old[7:4]}, lcd_rs<=old[0],
//   lcd_valid=1 one cycle after port_wr, phase<=HIGH. Old P1=1 (LCD read) strobes ignored.
//  nib_clr same cycle as a strobe: nib_clr wins, strobe discarded. rst mid-transaction: everything to reset values; bus ignored until next START.
//  Back-to-back bytes in one transaction each produce port_wr; no FIFO, consumer must accept lcd_valid every cycle.
// CONFIGURATION
//  Macro I2C_TGT_READ_EN.
//  Defined: address match with R/W=1 is ACKed -> RD_DATA: drive port_out MSB first (sda_oe=~bit), set on SCL fall;
//   after 8 bits release -> RD_ACK: sample master bit on SCL rise; 0 (ACK) -> RD_DATA reloads port_out; 1 (NACK) -> IGNORE.
//  Undefined: read address NACKed (sda_oe stays 0) -> IGNORE; RD_DATA/RD_ACK states not built.
// TESTING
//  Write 0x4E,0x0C at 100 kHz -> ACK low on both 9th bits, port_out=0x0C, one port_wr, no lcd_valid.
//  Write 0x4E,0x2C,0x28,0x8D,0x89 (cmd 0x28: hi 2 then lo 8, RS=0... 0x8D/0x89 lo nibble 8 RS=1)
//   -> after 0x28: phase LOW; after 0x89: lcd_valid once, lcd_byte=0x28, lcd_rs=1.
//  Address 0x4C (0x26 write) -> SDA never pulled low, port_out unchanged, busy=1 until STOP.
//  STOP after 4 data bits of 0xFF -> FSM IDLE, busy=0, port_out unchanged, sda_oe=0.
//  Repeated START after 0x4E,0x04 then 0x4E,0x00 -> second byte completes E strobe, phase toggles once.
//  With I2C_TGT_READ_EN: write 0xA5, then read 0x4F, master ACK then NACK -> SDA shows 0xA5 twice, FSM IGNORE until STOP; without: 0x4F NACKed.

Source files
------------

// File: rtl/i2c_lcd_target.sv
// PCF8574-style I2C write target that also reassembles HD44780 4-bit transfers into lcd bytes; optional read-back under I2C_TGT_READ_EN.
// Latency: 3 clk from pad to edge detect; port_wr on the 8th SCL fall of a data byte, lcd_valid one cycle later.
// Backpressure: none; SCL is never stretched and lcd_valid must be taken every cycle.
module i2c_lcd_target #(
  parameter logic [6:0] I2C_ADDR = 7'h27,
  parameter logic [7:0] PORT_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       nib_clr,
  output logic [7:0] port_out,
  output logic       port_wr,
  output logic       lcd_valid,
  output logic [7:0] lcd_byte,
  output logic       lcd_rs,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
`ifdef I2C_TGT_READ_EN
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
`endif
  localparam logic [2:0] IGNORE   = 3'd7;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;

  logic       stb;
  logic [3:0] stb_nib;
  logic       stb_rs;
  logic       phase;
  logic [3:0] nib_hi;

  // Synchronisers idle high so reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      port_out <= PORT_RST;
      port_wr  <= 1'b0;
      stb      <= 1'b0;
      stb_nib  <= 4'd0;
      stb_rs   <= 1'b0;
    end else begin
      port_wr <= 1'b0;
      stb     <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == WR_DATA) begin
                // A write strobe is E falling with RW low on the byte being replaced.
                stb      <= port_out[2] & ~shreg[2] & ~port_out[1];
                stb_nib  <= port_out[7:4];
                stb_rs   <= port_out[0];
                port_out <= shreg;
                port_wr  <= 1'b1;
                sda_oe   <= 1'b1;
                state    <= WR_ACK;
              end else if (shreg[7:1] != I2C_ADDR) begin
                state <= IGNORE;
              end else if (!shreg[0]) begin
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
`ifdef I2C_TGT_READ_EN
                sda_oe <= 1'b1;
                shreg  <= port_out;
                state  <= RD_DATA;
`else
                state  <= IGNORE;
`endif
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
`ifdef I2C_TGT_READ_EN
          // First fall here ends the ACK clock and presents bit 7; the 9th releases the bus.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe  <= ~shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                shreg   <= port_out;
                bit_cnt <= 4'd0;
                state   <= RD_DATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      nib_hi    <= 4'd0;
      lcd_valid <= 1'b0;
      lcd_byte  <= 8'h00;
      lcd_rs    <= 1'b0;
    end else begin
      lcd_valid <= 1'b0;
      if (nib_clr) begin
        phase <= 1'b0;
      end else if (stb) begin
        if (!phase) begin
          nib_hi <= stb_nib;
          phase  <= 1'b1;
        end else begin
          lcd_byte  <= {nib_hi, stb_nib};
          lcd_rs    <= stb_rs;
          lcd_valid <= 1'b1;
          phase     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_lcd_target.sv
// Bench for i2c_lcd_target: bit-banged I2C master, LCD nibble reference model, directed then random transactions.
module tb_i2c_lcd_target;
  localparam int Q = 10;
  localparam logic [6:0] ADDR = 7'h27;

  logic clk = 1'b0;
  logic rst, scl_m, sda_m, nib_clr;
  logic sda_oe, port_wr, lcd_valid, lcd_rs, busy;
  logic [7:0] port_out, lcd_byte;
  logic sda_bus;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_lcd_target #(.I2C_ADDR(7'h27), .PORT_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .nib_clr(nib_clr), .port_out(port_out), .port_wr(port_wr),
    .lcd_valid(lcd_valid), .lcd_byte(lcd_byte), .lcd_rs(lcd_rs), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  // Observations from the DUT.
  int wr_cnt = 0;
  int oe_hi = 0;
  int oe_viol = 0;
  logic oe_prev = 1'b0;
  logic [7:0] got_b[$];
  logic got_rs[$];

  always @(negedge clk) begin
    if (port_wr === 1'b1) wr_cnt++;
    if (sda_oe === 1'b1) oe_hi++;
    if (lcd_valid === 1'b1) begin
      got_b.push_back(lcd_byte);
      got_rs.push_back(lcd_rs);
    end
    if (rst === 1'b0 && scl_m === 1'b1 && sda_oe !== oe_prev) oe_viol++;
    oe_prev = sda_oe;
  end

  // Reference model: expander pin image plus the HD44780 nibble pairing.
  logic [7:0] m_port;
  logic       m_phase;
  logic [3:0] m_hi;
  int         exp_wr;
  logic [7:0] exp_b[$];
  logic       exp_rs[$];
  int         rd_idx = 0;

  logic [7:0] tx[8];
  logic       ack;
  logic [7:0] d;
  int         h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] b);
    if (m_port[2] && !b[2] && !m_port[1]) begin
      if (!m_phase) begin
        m_hi = m_port[7:4];
      end else begin
        exp_b.push_back({m_hi, m_port[7:4]});
        exp_rs.push_back(m_port[0]);
      end
      m_phase = ~m_phase;
    end
    m_port = b;
    exp_wr++;
  endtask

  task automatic qtr();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b1; qtr(); qtr();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qtr();
    scl_m = 1'b1; qtr(); qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    a = sda_bus; qtr();
    scl_m = 1'b0; qtr();
  endtask

`ifdef I2C_TGT_READ_EN
  task automatic read_byte(output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; qtr();
      scl_m = 1'b1; qtr();
      v[i] = sda_bus; qtr();
      scl_m = 1'b0; qtr();
    end
  endtask
`endif

  task automatic verify(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_port"}, port_out, m_port);
    chk({tag, "_wr_cnt"}, wr_cnt, exp_wr);
    chk({tag, "_lcd_cnt"}, got_b.size(), exp_b.size());
    while (rd_idx < got_b.size() && rd_idx < exp_b.size()) begin
      chk({tag, "_lcd_byte"}, got_b[rd_idx], exp_b[rd_idx]);
      chk({tag, "_lcd_rs"}, got_rs[rd_idx], exp_rs[rd_idx]);
      rd_idx++;
    end
  endtask

  // One transaction: address, n data bytes, optional partial byte of tx[n], then STOP.
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input int abort_bits, input string tag);
    logic a_ok;
    logic matched;
    matched = (a == ADDR) && !rw;
    i2c_start();
    chk({tag, "_busy_start"}, busy, 1'b1);
    send_byte({a, rw}, a_ok);
    chk({tag, "_addr_ack"}, a_ok, matched ? 1'b0 : 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], a_ok);
      chk({tag, "_data_ack"}, a_ok, matched ? 1'b0 : 1'b1);
      if (matched) model_write(tx[i]);
    end
    for (int j = 0; j < abort_bits; j++) write_bit(tx[n][7-j]);
    chk({tag, "_busy_pre_stop"}, busy, 1'b1);
    i2c_stop();
    chk({tag, "_busy_stop"}, busy, 1'b0);
    chk({tag, "_oe_stop"}, sda_oe, 1'b0);
    verify(tag);
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; nib_clr = 1'b0;
    m_port = 8'h00; m_phase = 1'b0; m_hi = 4'd0; exp_wr = 0;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_port_out", port_out, 8'h00);
    chk("rst_port_wr", port_wr, 1'b0);
    chk("rst_lcd_valid", lcd_valid, 1'b0);
    chk("rst_lcd_byte", lcd_byte, 8'h00);
    chk("rst_lcd_rs", lcd_rs, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain write: one port update, no E strobe.
    tx[0] = 8'h0C;
    xfer(ADDR, 1'b0, 1, 0, "wr_0c");
    chk("wr_0c_port_const", port_out, 8'h0C);
    chk("wr_0c_no_lcd", got_b.size(), 0);

    // Command nibbles 2 then 8, the second carried with RS=1.
    tx[0] = 8'h2C; tx[1] = 8'h28; tx[2] = 8'h8D; tx[3] = 8'h89;
    xfer(ADDR, 1'b0, 4, 0, "nib_pair");
    chk("nib_pair_one_valid", got_b.size(), 1);
    chk("nib_pair_byte_const", lcd_byte, 8'h28);
    chk("nib_pair_rs_const", lcd_rs, 1'b1);

    // Foreign address: bus never pulled, nothing written.
    h0 = oe_hi;
    tx[0] = 8'h00;
    xfer(7'h26, 1'b0, 1, 0, "foreign");
    chk("foreign_oe_never", oe_hi - h0, 0);

    // STOP in the middle of a data byte.
    tx[0] = 8'hFF;
    xfer(ADDR, 1'b0, 0, 4, "abort");

    // Repeated START between the E-high and E-low bytes.
    i2c_start();
    send_byte(8'h4E, ack); chk("rs_addr1_ack", ack, 1'b0);
    send_byte(8'h04, ack); chk("rs_d1_ack", ack, 1'b0); model_write(8'h04);
    i2c_start();
    chk("rs_busy", busy, 1'b1);
    send_byte(8'h4E, ack); chk("rs_addr2_ack", ack, 1'b0);
    send_byte(8'h00, ack); chk("rs_d2_ack", ack, 1'b0); model_write(8'h00);
    i2c_stop();
    verify("rstart");

    // nib_clr realigns the pairing after the dangling high nibble.
    @(negedge clk) nib_clr = 1'b1;
    @(negedge clk) nib_clr = 1'b0;
    m_phase = 1'b0;
    tx[0] = 8'h54; tx[1] = 8'h50; tx[2] = 8'h34; tx[3] = 8'h30;
    xfer(ADDR, 1'b0, 4, 0, "nibclr");
    chk("nibclr_byte_const", lcd_byte, 8'h53);
    chk("nibclr_rs_const", lcd_rs, 1'b0);

`ifdef I2C_TGT_READ_EN
    tx[0] = 8'hA5;
    xfer(ADDR, 1'b0, 1, 0, "pre_read");
    i2c_start();
    send_byte(8'h4F, ack); chk("rd_addr_ack", ack, 1'b0);
    read_byte(d); chk("rd_byte0", d, 8'hA5);
    write_bit(1'b0);
    read_byte(d); chk("rd_byte1", d, m_port);
    write_bit(1'b1);
    read_byte(d); chk("rd_after_nack", d, 8'hFF);
    chk("rd_busy_ignore", busy, 1'b1);
    chk("rd_oe_ignore", sda_oe, 1'b0);
    i2c_stop();
    chk("rd_busy_stop", busy, 1'b0);
    verify("read");
`else
    xfer(ADDR, 1'b1, 0, 0, "rd_nack");
`endif

    // Randomised transactions against the model.
    for (int t = 0; t < 25; t++) begin
      logic [6:0] a;
      logic rw;
      logic [7:0] b, last;
      int n, ab;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = a ^ 7'h01;
        rw = 1'($urandom_range(0, 1));
      end else begin
        a = ADDR;
        rw = 1'b0;
      end
      n = $urandom_range(1, 4);
      last = m_port;
      for (int i = 0; i <= n; i++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) b[2] = ~last[2];
        if ($urandom_range(0, 3) != 0) b[1] = 1'b0;
        tx[i] = b;
        last = b;
      end
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk) nib_clr = 1'b1;
        @(negedge clk) nib_clr = 1'b0;
        m_phase = 1'b0;
      end
      xfer(a, rw, n, ab, "rand");
    end

    chk("oe_stable_while_scl_high", oe_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
